simpson_seq: RTL
================

# simpson_seq

Operand sequencer for the Simpson's-rule integrator core. It collects an odd number of sample words from the switches, one per debounced button click, into a local buffer. It then streams the buffered samples into the core using the core's single-cycle input strobe, waits for the core's ready or error flag, and latches the result for the seven-segment and LED path. It sits between the debouncer/switch inputs and the integrator FSM in the top level.

## Interface
- WIDTH, 16, sample and result word width
- MAX_PTS, 9, buffer depth; maximum sample count (odd, ≤15)
- GAP, 4, cycles between successive core_valid pulses (≥1)
- TIMEOUT, 1000000, cycles allowed in WAIT before a timeout fault
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-low; 0 at an edge resets the block
- btn_click  in  1  one-cycle debounced click pulse
- sw  in  WIDTH  sample value; sampled on btn_click
- npts  in  4  requested sample count; sampled on the IDLE click
- core_data  out  WIDTH  sample driven to the core's dataIn
- core_valid  out  1  one-cycle strobe to the core's R_I
- core_result  in  WIDTH  core dataOut
- core_done  in  1  core R_O
- core_err  in  1  core Error
- result  out  WIDTH  latched integral
- result_valid  out  1  high while in DONE
- err  out  1  high while in FAULT
- err_code  out  2  0 none, 1 bad npts, 2 core error, 3 timeout
- busy  out  1  high in FEED, GAP, WAIT
- entry_cnt  out  4  samples stored so far

## Operation
- States: IDLE, LOAD, FEED, GAPW, WAIT, DONE, FAULT.
- IDLE: cnt=0.
  - On btn_click, capture npts.
  - If npts is even, <3 or >MAX_PTS: go to FAULT with err_code=1; sw is not stored.
  - Otherwise store sw in buf[0], set cnt=1, go to LOAD.
- LOAD: each btn_click stores sw in buf[cnt] and increments cnt. The click that makes cnt==npts goes to FEED with idx=0.
- FEED (one cycle): core_data=buf[idx], core_valid=1, idx++.
  - If idx was npts-1, go to WAIT.
  - Otherwise go to GAPW.
- GAPW: hold for GAP-1 cycles, then go to FEED. If GAP=1, GAPW is skipped and FEED repeats every cycle.
- core_data holds the last issued sample until the next issue. It is 0 out of reset.
- WAIT: the watchdog counts from 0.
  - core_err → FAULT, err_code=2. Error wins if core_err and core_done arrive in the same cycle.
  - Else core_done → result=core_result, go to DONE.
  - Else the watchdog reaching TIMEOUT → FAULT, err_code=3. core_done wins if it arrives in the same cycle as the timeout.
- core_err during FEED or GAPW → FAULT code 2, and no further pulses are issued.
- core_done outside WAIT is ignored.
- btn_click during FEED, GAPW or WAIT is ignored.
- DONE / FAULT: outputs are held. The next btn_click returns to IDLE and clears result_valid, err and err_code; result keeps its value. That click is not treated as a sample.
- reset low at any state: IDLE next cycle. Reset forces result=0, result_valid=0, err=0, err_code=0, busy=0, entry_cnt=0, core_valid=0 and core_data=0. Buffer contents are undefined after reset.

## Timing
- The completing click at edge k puts FEED in cycle k+1; the first core_valid is high during cycle k+1.
- Pulse n (0-based) is at cycle k+1+n·GAP. WAIT is entered one cycle after the last pulse.
- core_done sampled high at edge m: result and result_valid are visible after edge m (one-cycle latency).
- Timeout fires at the edge where the watchdog has counted TIMEOUT cycles of WAIT.
- entry_cnt updates on the same edge as the storing click.

## Test plan
- Reset: hold reset=0 for 3 cycles with btn_click toggling → all outputs 0, state IDLE, no core_valid.
- Nominal: GAP=4, npts=3, clicks with sw=0x0001, 0x0002, 0x0003; core model asserts core_done with 0x0010 twenty cycles after the last pulse.
  - Required: core_valid pulses exactly 4 cycles apart carrying 1, 2, 3.
  - Required: result=0x0010 and result_valid=1 one cycle after core_done.
  - Required: the next click clears result_valid.
- Bad count: npts=4, click → err=1, err_code=1, entry_cnt=0, no core_valid. Repeat with npts=11 and MAX_PTS=9 → same response.
- Core error: core_err and core_done high together in WAIT → err_code=2, result unchanged, result_valid=0. core_err during GAPW after pulse 1 of 5 → FAULT, no further pulses.
- Timeout: TIMEOUT=100, core silent → FAULT, err_code=3, exactly 100 cycles after WAIT entry. core_done on the same edge as the timeout → DONE.
- Abort/ignore: clicks during FEED/GAPW are ignored and entry_cnt is unchanged. Reset low after pulse 2 of 5 → no further core_valid, IDLE next cycle; a fresh 3-sample run then completes normally.

Source files
------------

// File: rtl/simpson_seq.sv
// Operand sequencer for the Simpson's-rule integrator core: buffers an odd number
// of switch samples, strobes them into the core every GAP cycles, latches the answer.
module simpson_seq #(
  parameter int WIDTH   = 16,
  parameter int MAX_PTS = 9,
  parameter int GAP     = 4,
  parameter int TIMEOUT = 1000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_click,
  input  logic [WIDTH-1:0] sw,
  input  logic [3:0]       npts,
  output logic [WIDTH-1:0] core_data,
  output logic             core_valid,
  input  logic [WIDTH-1:0] core_result,
  input  logic             core_done,
  input  logic             core_err,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             err,
  output logic [1:0]       err_code,
  output logic             busy,
  output logic [3:0]       entry_cnt
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    FEED  = 3'd2,
    GAPW  = 3'd3,
    WAIT  = 3'd4,
    DONE  = 3'd5,
    FAULT = 3'd6
  } state_t;

  localparam int               WD_W       = $clog2(TIMEOUT + 1);
  localparam int               GAP_W      = (GAP > 2) ? $clog2(GAP) : 1;
  localparam logic [WD_W-1:0]  WD_LAST    = WD_W'(TIMEOUT - 1);
  localparam logic [WD_W-1:0]  WD_ONE     = WD_W'(1);
  localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'((GAP >= 2) ? (GAP - 2) : 0);
  localparam logic [GAP_W-1:0] GAP_ONE    = GAP_W'(1);
  localparam logic             GAP_IS_ONE = (GAP == 1);
  localparam logic [3:0]       MAX_N      = 4'(MAX_PTS);
  localparam logic [1:0]       ERR_NONE   = 2'd0;
  localparam logic [1:0]       ERR_NPTS   = 2'd1;
  localparam logic [1:0]       ERR_CORE   = 2'd2;
  localparam logic [1:0]       ERR_TMO    = 2'd3;

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [3:0]         npts_q, npts_d;
  logic [3:0]         idx_q, idx_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic [WIDTH-1:0]   samp_q [MAX_PTS];
  logic [WIDTH-1:0]   samp_d [MAX_PTS];
  logic [WIDTH-1:0]   core_data_q, core_data_d;
  logic               core_valid_q, core_valid_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               result_valid_q, result_valid_d;
  logic               err_q, err_d;
  logic [1:0]         err_code_q, err_code_d;
  logic               busy_q, busy_d;
  logic [3:0]         feed_idx;
  logic               npts_bad;

  // Next-state, buffer writes and registered-output values for the coming cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    npts_d     = npts_q;
    gap_d      = gap_q;
    wd_d       = wd_q;
    samp_d     = samp_q;
    result_d   = result_q;
    err_code_d = err_code_q;
    feed_idx   = idx_q;
    npts_bad   = (npts < 4'd3) || (npts > MAX_N) || (npts[0] == 1'b0);

    case (state_q)
      IDLE: begin
        cnt_d = 4'd0;
        if (btn_click) begin
          npts_d = npts;
          if (npts_bad) begin
            state_d    = FAULT;
            err_code_d = ERR_NPTS;
          end else begin
            samp_d[0] = sw;
            cnt_d     = 4'd1;
            state_d   = LOAD;
          end
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        if (btn_click) begin
          samp_d[cnt_q] = sw;
          cnt_d         = cnt_q + 4'd1;
          if ((cnt_q + 4'd1) == npts_q) begin
            state_d  = FEED;
            feed_idx = 4'd0;
          end else begin
            state_d = LOAD;
          end
        end else begin
          state_d = LOAD;
        end
      end
      // idx_q already points past the word issued this cycle
      FEED: begin
        if (core_err) begin
          state_d    = FAULT;
          err_code_d = ERR_CORE;
        end else if (idx_q == npts_q) begin
          state_d = WAIT;
          wd_d    = {WD_W{1'b0}};
        end else if (GAP_IS_ONE) begin
          state_d = FEED;
        end else begin
          state_d = GAPW;
          gap_d   = {GAP_W{1'b0}};
        end
      end
      GAPW: begin
        if (core_err) begin
          state_d    = FAULT;
          err_code_d = ERR_CORE;
        end else if (gap_q == GAP_LAST) begin
          state_d = FEED;
        end else begin
          state_d = GAPW;
          gap_d   = gap_q + GAP_ONE;
        end
      end
      WAIT: begin
        if (core_err) begin
          state_d    = FAULT;
          err_code_d = ERR_CORE;
        end else if (core_done) begin
          state_d  = DONE;
          result_d = core_result;
        end else if (wd_q == WD_LAST) begin
          state_d    = FAULT;
          err_code_d = ERR_TMO;
        end else begin
          state_d = WAIT;
          wd_d    = wd_q + WD_ONE;
        end
      end
      DONE, FAULT: begin
        if (btn_click) begin
          state_d    = IDLE;
          cnt_d      = 4'd0;
          err_code_d = ERR_NONE;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_d == FEED) begin
      core_valid_d = 1'b1;
      core_data_d  = samp_q[feed_idx];
      idx_d        = feed_idx + 4'd1;
    end else begin
      core_valid_d = 1'b0;
      core_data_d  = core_data_q;
      idx_d        = idx_q;
    end

    result_valid_d = (state_d == DONE);
    err_d          = (state_d == FAULT);
    busy_d         = (state_d == FEED) || (state_d == GAPW) || (state_d == WAIT);
  end

  // State and output registers; sample buffer is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= IDLE;
      cnt_q          <= 4'd0;
      npts_q         <= 4'd0;
      idx_q          <= 4'd0;
      gap_q          <= {GAP_W{1'b0}};
      wd_q           <= {WD_W{1'b0}};
      core_data_q    <= {WIDTH{1'b0}};
      core_valid_q   <= 1'b0;
      result_q       <= {WIDTH{1'b0}};
      result_valid_q <= 1'b0;
      err_q          <= 1'b0;
      err_code_q     <= ERR_NONE;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      npts_q         <= npts_d;
      idx_q          <= idx_d;
      gap_q          <= gap_d;
      wd_q           <= wd_d;
      core_data_q    <= core_data_d;
      core_valid_q   <= core_valid_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      err_q          <= err_d;
      err_code_q     <= err_code_d;
      busy_q         <= busy_d;
      samp_q         <= samp_d;
    end
  end

  assign core_data    = core_data_q;
  assign core_valid   = core_valid_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign err          = err_q;
  assign err_code     = err_code_q;
  assign busy         = busy_q;
  assign entry_cnt    = cnt_q;

endmodule
